// File: rtl/x_sched.sv
// x_sched: round-robin two-requester scheduler feeding x_driver nibble commands.
// Optional WAIT abort compiled in with X_SCHED_TIMEOUT_EN.
module x_sched #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic [31:0] i_word0,
  output logic        o_done0,
  input  logic        i_req1,
  input  logic [31:0] i_word1,
  output logic        o_done1,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_data,
  input  logic        i_drv_valid,
  input  logic        i_drv_accept,
  output logic        o_busy,
  output logic        o_timeout
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_to_chk
    $error("x_sched: TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, UNLOAD, WAIT, DONE
  } state_t;

  state_t      state_q;
  logic [31:0] word_q;
  logic        owner_q;
  logic        rr_last_q;
  logic [3:0]  nib_q;
  logic [1:0]  byte_q;
`ifdef X_SCHED_TIMEOUT_EN
  logic [7:0]  wcnt_q;
`endif

  logic        gnt_any;
  logic        gnt1;
  logic [31:0] win_w;
  logic        byte_ok;
  logic [4:0]  nib_base;

  assign gnt_any  = i_req0 | i_req1;
  // On a tie the requester that did not win last time gets the grant.
  assign gnt1     = i_req1 & (~i_req0 | ~rr_last_q);
  assign win_w    = gnt1 ? i_word1 : i_word0;
  assign byte_ok  = i_drv_valid & i_drv_accept;
  assign nib_base = 5'd28 - {nib_q[2:0], 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      nib_q       <= '0;
      byte_q      <= '0;
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd_data  <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
`ifdef X_SCHED_TIMEOUT_EN
      wcnt_q      <= '0;
`endif
    end else begin
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd_data  <= '0;
      o_timeout   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            state_q     <= LOAD;
            word_q      <= win_w;
            owner_q     <= gnt1;
            rr_last_q   <= gnt1;
            // first nibble leaves with the grant edge
            nib_q       <= 4'd1;
            byte_q      <= '0;
            o_cmd_valid <= 1'b1;
            o_cmd_data  <= {win_w[31:28], 4'h0};
            o_busy      <= 1'b1;
          end
        end
        LOAD: begin
          o_cmd_valid <= 1'b1;
          if (nib_q == 4'd8) begin
            state_q    <= UNLOAD;
            o_cmd_data <= 8'h01;
          end else begin
            o_cmd_data <= {word_q[nib_base +: 4], 4'h0};
            nib_q      <= nib_q + 4'd1;
          end
        end
        UNLOAD: begin
          state_q <= WAIT;
`ifdef X_SCHED_TIMEOUT_EN
          wcnt_q  <= '0;
`endif
        end
        WAIT: begin
          if (byte_ok) begin
            if (byte_q == 2'd3) begin
              state_q <= DONE;
              o_done0 <= ~owner_q;
              o_done1 <= owner_q;
            end else begin
              state_q     <= UNLOAD;
              byte_q      <= byte_q + 2'd1;
              o_cmd_valid <= 1'b1;
              o_cmd_data  <= 8'h01;
            end
          end
`ifdef X_SCHED_TIMEOUT_EN
          else if (wcnt_q == 8'(TIMEOUT - 1)) begin
            state_q   <= IDLE;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_sched.sv
// tb_x_sched: directed bench for x_sched with a small behavioural driver model.
// Expected command/byte/done timings are hand-computed per scenario.
module tb_x_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1;
  logic [31:0] w0, w1;
  logic        acc;
  logic        mute;
  logic        done0, done1, cv, busy, tmo;
  logic [7:0]  cd;
  logic        dv;

  logic        dv_q;
  logic [31:0] sr;
  logic [7:0]  dbyte;

  assign dv = dv_q & ~mute;

  x_sched #(.TIMEOUT(10)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0       (req0),
    .i_word0      (w0),
    .o_done0      (done0),
    .i_req1       (req1),
    .i_word1      (w1),
    .o_done1      (done1),
    .o_cmd_valid  (cv),
    .o_cmd_data   (cd),
    .i_drv_valid  (dv),
    .i_drv_accept (acc),
    .o_busy       (busy),
    .o_timeout    (tmo)
  );

  int   cyc = 0;
  int   t0 = 0;
  int   mode = 0;
  int   vwait = 0;
  int   c_t[$], c_d[$], b_v[$], b_t[$];
  int   d0[$], d1[$], to_t[$];
  int   busy_on = -1, busy_off = -1;
  logic busy_p = 1'b0;
  int   n_chk = 0, n_bad = 0;

  // driver model: shifts nibbles in, presents a byte after each unload
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      dv_q  <= 1'b0;
      sr    <= '0;
      dbyte <= '0;
      vwait <= 0;
    end else begin
      vwait <= (dv & ~acc) ? vwait + 1 : 0;
      if (dv & acc) begin
        b_v.push_back(int'(dbyte));
        b_t.push_back(cyc);
        dv_q <= 1'b0;
      end
      if (cv) begin
        if (cd == 8'h01) begin
          dbyte <= sr[31:24];
          sr    <= {sr[23:0], 8'h00};
          dv_q  <= 1'b1;
        end else begin
          sr <= {sr[27:0], cd[7:4]};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cv) begin
      c_t.push_back(cyc);
      c_d.push_back(int'(cd));
    end
    if (done0) d0.push_back(cyc);
    if (done1) d1.push_back(cyc);
    if (tmo) to_t.push_back(cyc);
    if (busy && !busy_p) busy_on <= cyc;
    if (!busy && busy_p) busy_off <= cyc;
    busy_p <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qg(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick;
    int rel;
    @(negedge clk);
    #1;
    rel = cyc - t0;
    case (mode)
      0: acc = 1'b1;
      1: acc = (vwait >= 5);
      2: begin
        acc  = 1'b1;
        mute = (rel >= 10 && rel <= 13);
      end
      default: acc = 1'b0;
    endcase
  endtask

  task automatic clr;
    c_t.delete(); c_d.delete(); b_v.delete(); b_t.delete();
    d0.delete(); d1.delete(); to_t.delete();
    busy_on = -1;
    busy_off = -1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic start(input logic r0, input logic r1, input logic hold);
    clr;
    t0 = cyc;
    req0 = r0;
    req1 = r1;
    if (!hold) begin
      tick;
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while ((d0.size() + d1.size() + to_t.size()) < n && k < budget) begin
      tick;
      k++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("ends_seen", d0.size() + d1.size() + to_t.size(), n);
    repeat (2) tick;
  endtask

  task automatic chk_cmds(input string tag, input logic [31:0] w,
                          input int u0, input int u1,
                          input int u2, input int u3);
    int ul[4];
    logic [31:0] s;
    ul = '{u0, u1, u2, u3};
    chk({tag, "_ncmd"}, c_t.size(), 12);
    for (int k = 0; k < 8; k++) begin
      s = w << (4 * k);
      chk({tag, "_ld_t"}, qg(c_t, k) - t0, k + 1);
      chk({tag, "_ld_d"}, qg(c_d, k), {24'h0, s[31:28], 4'h0});
    end
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_ul_t"}, qg(c_t, 8 + k) - t0, ul[k]);
      chk({tag, "_ul_d"}, qg(c_d, 8 + k), 32'h01);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [31:0] w,
                           input int base);
    logic [31:0] s;
    for (int k = 0; k < 4; k++) begin
      s = w << (8 * k);
      chk({tag, "_byte"}, qg(b_v, base + k), {24'h0, s[31:24]});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    w0 = '0; w1 = '0; acc = 1'b0; mute = 1'b0; mode = 0;
    repeat (2) tick;
    chk("rst_valid", cv, 0);
    chk("rst_data", cd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_tmo", tmo, 0);
    rst = 1'b0;
    tick;

    // reset after three loads, then a clean transaction
    w0 = 32'h12345678;
    start(1'b1, 1'b0, 1'b0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("mid_valid", cv, 0);
    chk("mid_data", cd, 0);
    chk("mid_busy", busy, 0);
    rst = 1'b0;
    chk("mid_ncmd", c_t.size(), 3);
    repeat (20) tick;
    chk("mid_nodone", d0.size() + d1.size(), 0);
    w1 = 32'h9ABCDEF0;
    start(1'b0, 1'b1, 1'b0);
    wait_done(1, 40);
    chk_cmds("after_rst", w1, 9, 11, 13, 15);
    chk_bytes("after_rst", w1, 0);
    chk("after_rst_done1", qg(d1, 0) - t0, 17);

    // single request, accept held high
    w0 = 32'hA1B2C3D4;
    start(1'b1, 1'b0, 1'b0);
    wait_done(1, 40);
    chk_cmds("single", w0, 9, 11, 13, 15);
    chk_bytes("single", w0, 0);
    chk("single_nd0", d0.size(), 1);
    chk("single_done0", qg(d0, 0) - t0, 17);
    chk("single_nd1", d1.size(), 0);
    chk("single_lastacc", qg(b_t, 3) - t0, 16);
    chk("single_busy_on", busy_on - t0, 1);
    chk("single_busy_off", busy_off - t0, 18);

    // both requests held: 0, 1, 0
    do_reset;
    w0 = 32'h13572468;
    w1 = 32'hCAFEBABE;
    start(1'b1, 1'b1, 1'b1);
    wait_done(3, 80);
    chk("rr_nd0", d0.size(), 2);
    chk("rr_nd1", d1.size(), 1);
    chk("rr_done0a", qg(d0, 0) - t0, 17);
    chk("rr_done1", qg(d1, 0) - t0, 35);
    chk("rr_done0b", qg(d0, 1) - t0, 53);
    chk("rr_ncmd", c_t.size(), 36);
    chk("rr_ld2_t", qg(c_t, 12) - t0, 19);
    chk("rr_ld2_d", qg(c_d, 12), 32'hC0);
    chk_bytes("rr_a", w0, 0);
    chk_bytes("rr_b", w1, 4);
    chk_bytes("rr_c", w0, 8);

    // accepts delayed five cycles after each byte appears
    w0 = 32'h0BADF00D;
    mode = 1;
    start(1'b1, 1'b0, 1'b0);
    wait_done(1, 80);
    mode = 0;
    chk_cmds("stall", w0, 9, 16, 23, 30);
    chk_bytes("stall", w0, 0);
    chk("stall_acc0", qg(b_t, 0) - t0, 15);
    chk("stall_acc1", qg(b_t, 1) - t0, 22);
    chk("stall_acc2", qg(b_t, 2) - t0, 29);
    chk("stall_acc3", qg(b_t, 3) - t0, 36);
    chk("stall_done0", qg(d0, 0) - t0, 37);

    // accept high while driver byte is not valid
    w0 = 32'h55AA33CC;
    mode = 2;
    start(1'b1, 1'b0, 1'b0);
    wait_done(1, 60);
    mode = 0;
    mute = 1'b0;
    chk_cmds("ign", w0, 9, 15, 17, 19);
    chk("ign_acc0", qg(b_t, 0) - t0, 14);
    chk("ign_done0", qg(d0, 0) - t0, 21);

    // word changes during LOAD are not seen
    w0 = 32'h11223344;
    start(1'b1, 1'b0, 1'b0);
    tick;
    w0 = 32'hFFFFFFFF;
    wait_done(1, 40);
    chk_cmds("wchg", 32'h11223344, 9, 11, 13, 15);
    chk_bytes("wchg", 32'h11223344, 0);

`ifdef X_SCHED_TIMEOUT_EN
    // no accept: abort after ten WAIT cycles, pending requester 1 follows
    do_reset;
    w0 = 32'hCAFE0001;
    w1 = 32'h12345678;
    mode = 3;
    start(1'b1, 1'b0, 1'b0);
    while (cyc - t0 < 5) tick;
    req1 = 1'b1;
    while (to_t.size() == 0 && cyc - t0 < 40) tick;
    chk("to_seen", to_t.size(), 1);
    while (cyc - t0 < 22) tick;
    req1 = 1'b0;
    chk("to_cycle", qg(to_t, 0) - t0, 20);
    chk("to_nodone", d0.size() + d1.size(), 0);
    chk("to_next_t", qg(c_t, 12) - t0, 21);
    chk("to_next_d", qg(c_d, 12), 32'h10);
    mode = 0;
    do_reset;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
